sa_conv_engine: RTL and testbench

SA_CONV_ENGINE -- requirements
Module: sa_conv_engine

---
 rtl/sa_conv_engine.sv | 190 +++++++++++++++++++
 tb/tb_sa_conv_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_conv_engine.sv
// -----------------------------------------------------------------------------
// sa_conv_engine
//
// Purpose:
//   Valid-convolution engine. A start pulse captures a square image and a
//   square kernel. The engine then produces one result per output pixel in
//   row-major order. Each pixel takes KER_N cycles: every cycle it adds one
//   kernel row, using KER_N parallel unsigned multipliers. Each result is held
//   on the output until the consumer accepts it.
//
// Build option:
//   SA_SAT_EN  when defined, the result is the accumulator saturated to
//              2^DATA_W-1. Otherwise the result is the low DATA_W bits of the
//              accumulator.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   en_sa         start pulse, sampled only in IDLE
//   img_flat      IMG_N x IMG_N image, element (r,c) at [(r*IMG_N+c)*DATA_W +: DATA_W]
//   ker_flat      KER_N x KER_N kernel, same packing
//   out_ready     consumer accepts the presented result
//   sa_busy       a frame is in progress
//   sa_en_result  sa_result is valid
//   sa_result     convolution result
//   sa_last       the presented result is the final pixel of the frame
//   sa_done       one-cycle pulse after the final result is accepted
// -----------------------------------------------------------------------------
module sa_conv_engine #(
  parameter int DATA_W = 8,
  parameter int IMG_N  = 4,
  parameter int KER_N  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en_sa,
  input  logic [IMG_N*IMG_N*DATA_W-1:0] img_flat,
  input  logic [KER_N*KER_N*DATA_W-1:0] ker_flat,
  input  logic                          out_ready,
  output logic                          sa_busy,
  output logic                          sa_en_result,
  output logic [DATA_W-1:0]             sa_result,
  output logic                          sa_last,
  output logic                          sa_done
);

  localparam int OUT_N    = IMG_N - KER_N + 1;
  localparam int ACC_W    = 2*DATA_W + $clog2(KER_N*KER_N);
  localparam int PW       = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int RW       = (KER_N > 1) ? $clog2(KER_N) : 1;
  localparam int IMG_BITS = IMG_N*IMG_N*DATA_W;
  localparam int KER_BITS = KER_N*KER_N*DATA_W;

  localparam logic [PW-1:0]    POS_LAST = PW'(OUT_N - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(KER_N - 1);
  localparam logic [ACC_W-1:0] RES_MAX  = ACC_W'({DATA_W{1'b1}});

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  function automatic logic [DATA_W-1:0] to_result(input logic [ACC_W-1:0] acc);
`ifdef SA_SAT_EN
    if (acc > RES_MAX) return {DATA_W{1'b1}};
    return DATA_W'(acc);
`else
    return DATA_W'(acc);
`endif
  endfunction

  state_t              state_q, state_d;
  logic [IMG_BITS-1:0] img_q, img_d;
  logic [KER_BITS-1:0] ker_q, ker_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PW-1:0]       pr_q, pr_d;
  logic [PW-1:0]       pc_q, pc_d;
  logic [RW-1:0]       row_q, row_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                vld_q, vld_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    row_sum;
  logic [ACC_W-1:0]    acc_sum;
  logic                last_pix;

  assign last_pix = (pr_q == POS_LAST) && (pc_q == POS_LAST);

  // One kernel row against the image window row it overlaps.
  always_comb begin
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [2*DATA_W-1:0] prod;
    row_sum = '0;
    for (int k = 0; k < KER_N; k++) begin
      a = img_q[((int'(pr_q) + int'(row_q))*IMG_N + int'(pc_q) + k)*DATA_W +: DATA_W];
      b = ker_q[(int'(row_q)*KER_N + k)*DATA_W +: DATA_W];
      prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      row_sum = row_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    ker_d   = ker_q;
    acc_d   = acc_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    row_d   = row_q;
    res_d   = res_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    acc_sum = acc_q + row_sum;
    case (state_q)
      IDLE: begin
        // A start that lines up with the done pulse belongs to the old frame.
        if (en_sa && !done_q) begin
          img_d   = img_flat;
          ker_d   = ker_flat;
          acc_d   = '0;
          pr_d    = '0;
          pc_d    = '0;
          row_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_sum;
        if (row_q == ROW_LAST) begin
          res_d   = to_result(acc_sum);
          vld_d   = 1'b1;
          state_d = OUTPUT;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          vld_d = 1'b0;
          if (last_pix) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            acc_d   = '0;
            row_d   = '0;
            state_d = COMPUTE;
            if (pc_q == POS_LAST) begin
              pc_d = '0;
              pr_d = pr_q + 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      img_q   <= '0;
      ker_q   <= '0;
      acc_q   <= '0;
      pr_q    <= '0;
      pc_q    <= '0;
      row_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      ker_q   <= ker_d;
      acc_q   <= acc_d;
      pr_q    <= pr_d;
      pc_q    <= pc_d;
      row_q   <= row_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign sa_busy      = (state_q != IDLE);
  assign sa_en_result = vld_q;
  assign sa_result    = res_q;
  assign sa_last      = vld_q && last_pix;
  assign sa_done      = done_q;

endmodule

// File: tb/tb_sa_conv_engine.sv
// -----------------------------------------------------------------------------
// tb_sa_conv_engine
//
// Directed bench for sa_conv_engine. One instance uses the default 4x4 image
// and 3x3 kernel. A second instance uses a 5x5 image. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sa_conv_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         en_sa, out_ready;
  logic [127:0] img;
  logic [71:0]  ker;
  logic         busy, vld, last, done;
  logic [7:0]   res;

  logic         en5, rdy5;
  logic [199:0] img5;
  logic [71:0]  ker5;
  logic         busy5, vld5, last5, done5;
  logic [7:0]   res5;

  sa_conv_engine dut (
    .clk(clk), .reset(reset), .en_sa(en_sa), .img_flat(img), .ker_flat(ker),
    .out_ready(out_ready), .sa_busy(busy), .sa_en_result(vld),
    .sa_result(res), .sa_last(last), .sa_done(done)
  );

  sa_conv_engine #(.DATA_W(8), .IMG_N(5), .KER_N(3)) dut5 (
    .clk(clk), .reset(reset), .en_sa(en5), .img_flat(img5), .ker_flat(ker5),
    .out_ready(rdy5), .sa_busy(busy5), .sa_en_result(vld5),
    .sa_result(res5), .sa_last(last5), .sa_done(done5)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_r [0:15];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Waits at most 40 cycles for a valid result. The first falling edge comes
  // just after the capture or acceptance edge, so the latency is cnt-1 edges.
  task automatic get_result(input bit sel5, input bit drop, output logic [7:0] r,
                            output logic l, output int lat);
    int   cnt;
    logic v;
    cnt = 0;
    v   = 1'b0;
    while (!v && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        en_sa = 1'b0;
        en5   = 1'b0;
        if (drop) out_ready = 1'b0;
      end
      v = sel5 ? vld5 : vld;
    end
    if (!v) chk("timeout", 32'd0, 32'd1);
    r   = sel5 ? res5 : res;
    l   = sel5 ? last5 : last;
    lat = cnt - 1;
  endtask

  task automatic run_frame(input bit sel5, input int n, input string name);
    logic [7:0] r;
    logic       l;
    int         lat;
    for (int p = 0; p < n; p++) begin
      get_result(sel5, 1'b0, r, l, lat);
      chk($sformatf("%s res%0d", name, p), {24'd0, r}, {24'd0, exp_r[p]});
      chk($sformatf("%s lat%0d", name, p), lat, 3);
      chk($sformatf("%s last%0d", name, p), {31'd0, l}, {31'd0, (p == n - 1)});
    end
    @(negedge clk);
    chk({name, " done"}, {31'd0, sel5 ? done5 : done}, 32'd1);
    chk({name, " busy_at_done"}, {31'd0, sel5 ? busy5 : busy}, 32'd0);
    chk({name, " vld_at_done"}, {31'd0, sel5 ? vld5 : vld}, 32'd0);
    // A start presented during the done cycle must not launch a frame.
    if (sel5) en5 = 1'b1; else en_sa = 1'b1;
    @(negedge clk);
    en_sa = 1'b0;
    en5   = 1'b0;
    chk({name, " done_clr"}, {31'd0, sel5 ? done5 : done}, 32'd0);
    chk({name, " start_in_done_ignored"}, {31'd0, sel5 ? busy5 : busy}, 32'd0);
  endtask

  task automatic fill_const(input logic [7:0] iv, input logic [7:0] kv);
    for (int i = 0; i < 16; i++) img[i*8 +: 8] = iv;
    for (int i = 0; i < 9; i++)  ker[i*8 +: 8] = kv;
  endtask

  // Image a(r,c) = r*4+c with an all-ones kernel.
  // The 3x3 window sums are 45, 54, 81 and 90.
  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) img[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 9; i++)  ker[i*8 +: 8] = 8'd1;
  endtask

  logic [7:0] r;
  logic       l;
  int         lat;
  logic [7:0] held;

  initial begin
    reset = 1'b0; en_sa = 1'b0; out_ready = 1'b1; img = '0; ker = '0;
    en5 = 1'b0; rdy5 = 1'b1; img5 = '0; ker5 = '0;
    #3;
    chk("rst vld",  {31'd0, vld},  32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst res",  {24'd0, res},  32'd0);
    chk("rst last", {31'd0, last}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // All ones: every 3x3 window sums to 9.
    fill_const(8'd1, 8'd1);
    for (int i = 0; i < 4; i++) exp_r[i] = 8'd9;
    en_sa = 1'b1;
    run_frame(1'b0, 4, "ones");

    // All 255: 9*65025 = 585225 saturates to 255, or truncates to 9.
    fill_const(8'd255, 8'd255);
`ifdef SA_SAT_EN
    for (int i = 0; i < 4; i++) exp_r[i] = 8'd255;
`else
    for (int i = 0; i < 4; i++) exp_r[i] = 8'd9;
`endif
    en_sa = 1'b1;
    run_frame(1'b0, 4, "max");

    // Centre-only kernel selects a(pr+1,pc+1): 5, 6, 9, 10.
    for (int i = 0; i < 16; i++) img[i*8 +: 8] = 8'(i);
    ker = '0;
    ker[(1*3+1)*8 +: 8] = 8'd1;
    exp_r[0] = 8'd5; exp_r[1] = 8'd6; exp_r[2] = 8'd9; exp_r[3] = 8'd10;
    en_sa = 1'b1;
    run_frame(1'b0, 4, "centre");

    // Back-pressure on result 2, plus a stray start and input changes while busy.
    fill_ramp();
    out_ready = 1'b1;
    en_sa = 1'b1;
    get_result(1'b0, 1'b0, r, l, lat);
    chk("bp res0", {24'd0, r}, 32'd45);
    get_result(1'b0, 1'b1, r, l, lat);
    chk("bp res1", {24'd0, r}, 32'd54);
    chk("bp lat1", lat, 3);
    held = r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) img = '1;
      if (i == 1) en_sa = 1'b1;
      if (i == 2) en_sa = 1'b0;
      chk($sformatf("bp hold res c%0d", i), {24'd0, res}, {24'd0, held});
      chk($sformatf("bp hold vld c%0d", i), {31'd0, vld}, 32'd1);
    end
    out_ready = 1'b1;
    get_result(1'b0, 1'b0, r, l, lat);
    chk("bp res2", {24'd0, r}, 32'd81);
    chk("bp lat2", lat, 3);
    chk("bp last2", {31'd0, l}, 32'd0);
    get_result(1'b0, 1'b0, r, l, lat);
    chk("bp res3", {24'd0, r}, 32'd90);
    chk("bp last3", {31'd0, l}, 32'd1);
    @(negedge clk);
    chk("bp done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("bp idle_after", {31'd0, busy}, 32'd0);

    // Reset while pixel 1 is being computed.
    fill_const(8'd1, 8'd1);
    en_sa = 1'b1;
    get_result(1'b0, 1'b0, r, l, lat);
    chk("rstmid res0", {24'd0, r}, 32'd9);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid vld",  {31'd0, vld},  32'd0);
    chk("rstmid busy", {31'd0, busy}, 32'd0);
    chk("rstmid res",  {24'd0, res},  32'd0);
    chk("rstmid last", {31'd0, last}, 32'd0);
    chk("rstmid done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid quiet c%0d", i), {30'd0, busy, vld}, 32'd0);
    end
    fill_ramp();
    exp_r[0] = 8'd45; exp_r[1] = 8'd54; exp_r[2] = 8'd81; exp_r[3] = 8'd90;
    en_sa = 1'b1;
    run_frame(1'b0, 4, "after_rst");

    // 5x5 image of 2s against a 3x3 kernel of 2s: nine results of 9*4 = 36.
    for (int i = 0; i < 25; i++) img5[i*8 +: 8] = 8'd2;
    for (int i = 0; i < 9; i++)  ker5[i*8 +: 8] = 8'd2;
    for (int i = 0; i < 9; i++)  exp_r[i] = 8'd36;
    en5 = 1'b1;
    run_frame(1'b1, 9, "img5");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
